// File: rtl/moore_seq_gen.sv
// moore_seq_gen: serial pattern generator (Moore style).
// On an accepted start it captures a PAT_W-bit pattern, a repeat count and a
// gap length. It then shifts the pattern out MSB-first, one bit per clock, for
// repeat+1 frames. Consecutive frames are separated by gap zero bits.
// All outputs are registered and depend only on state.
//
// Ports:
//   clk         clock; all state updates on the rising edge
//   rst         asynchronous active-high reset
//   start       transfer request, sampled only in IDLE
//   pattern     bits to send, MSB first (captured on accepted start)
//   repeat_n    frames to send minus one (captured on accepted start);
//               named repeat_n because "repeat" is a reserved word
//   gap         zero bits between consecutive frames (captured on start)
//   x           serial data
//   busy        high in SEND, GAP and DONE
//   frame_done  high while the last bit of each frame is on x
//   done        one-cycle pulse after the last frame
module moore_seq_gen #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4,
    parameter int GAP_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic [GAP_W-1:0] gap,
    output logic             x,
    output logic             busy,
    output logic             frame_done,
    output logic             done
);

    localparam int BW = $clog2(PAT_W);
    localparam logic [BW-1:0] LAST   = BW'(PAT_W - 1);
    localparam logic [BW-1:0] PENULT = BW'(PAT_W - 2);

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t           state;
    logic [PAT_W-1:0] sh;       // bits still to be presented, MSB next
    logic [PAT_W-1:0] pat_c;    // captured pattern, reloaded per frame
    logic [GAP_W-1:0] gap_c;    // captured gap length
    logic [GAP_W-1:0] gapcnt;   // gap bits presented so far in this gap
    logic [CNT_W-1:0] frames;   // frames remaining after the current one
    logic [BW-1:0]    bitcnt;   // index of the bit currently on x

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            x          <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            done       <= 1'b0;
            sh         <= '0;
            pat_c      <= '0;
            gap_c      <= '0;
            gapcnt     <= '0;
            frames     <= '0;
            bitcnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    x          <= 1'b0;
                    busy       <= 1'b0;
                    frame_done <= 1'b0;
                    done       <= 1'b0;
                    if (start) begin
                        pat_c  <= pattern;
                        gap_c  <= gap;
                        frames <= repeat_n;
                        // MSB goes straight to x; sh holds the remainder
                        x      <= pattern[PAT_W-1];
                        sh     <= {pattern[PAT_W-2:0], 1'b0};
                        bitcnt <= '0;
                        busy   <= 1'b1;
                        state  <= SEND;
                    end
                end

                SEND: begin
                    if (bitcnt != LAST) begin
                        x          <= sh[PAT_W-1];
                        sh         <= {sh[PAT_W-2:0], 1'b0};
                        bitcnt     <= bitcnt + BW'(1);
                        // next presented bit is the frame's last
                        frame_done <= (bitcnt == PENULT);
                    end else begin
                        frame_done <= 1'b0;
                        if (frames != '0) begin
                            // count only frames still owed, so a full-scale
                            // repeat never wraps
                            frames <= frames - CNT_W'(1);
                            if (gap_c != '0) begin
                                x      <= 1'b0;
                                gapcnt <= GAP_W'(1);
                                state  <= GAP;
                            end else begin
                                // back-to-back frame, no idle bit
                                x      <= pat_c[PAT_W-1];
                                sh     <= {pat_c[PAT_W-2:0], 1'b0};
                                bitcnt <= '0;
                            end
                        end else begin
                            x     <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end

                GAP: begin
                    if (gapcnt == gap_c) begin
                        x      <= pat_c[PAT_W-1];
                        sh     <= {pat_c[PAT_W-2:0], 1'b0};
                        bitcnt <= '0;
                        state  <= SEND;
                    end else begin
                        gapcnt <= gapcnt + GAP_W'(1);
                    end
                end

                DONE: begin
                    // start is ignored here, so a held start yields one
                    // idle cycle before the next transfer
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_moore_seq_gen.sv
module tb_moore_seq_gen;
    localparam int PAT_W = 4;
    localparam int CNT_W = 4;
    localparam int GAP_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [PAT_W-1:0] pattern = '0;
    logic [CNT_W-1:0] rep = '0;
    logic [GAP_W-1:0] gap = '0;
    logic             x, busy, frame_done, done;

    moore_seq_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern),
        .repeat_n(rep), .gap(gap), .x(x), .busy(busy),
        .frame_done(frame_done), .done(done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int fd_cnt = 0;
    int done_cnt = 0;
    // expected {x, frame_done, done, busy} for each upcoming cycle;
    // an empty queue means the block is idle (all zero)
    logic [3:0] expq[$];
    logic       cur_busy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // whole transfer as a flat list of cycles
    task automatic enqueue(input logic [PAT_W-1:0] pat, input int r, input int g);
        for (int f = 0; f <= r; f++) begin
            for (int i = PAT_W - 1; i >= 0; i--)
                expq.push_back({pat[i], (i == 0), 1'b0, 1'b1});
            if (f < r)
                for (int j = 0; j < g; j++) expq.push_back(4'b0001);
        end
        expq.push_back(4'b0011);
    endtask

    // one clock: model decides acceptance from the current inputs, then
    // outputs of the new cycle are checked on the falling edge
    task automatic tick(input string tag);
        logic [3:0] e;
        if (!cur_busy && start) enqueue(pattern, int'(rep), int'(gap));
        @(posedge clk);
        @(negedge clk);
        e = (expq.size() != 0) ? expq.pop_front() : 4'b0000;
        chk(tag, {28'b0, x, frame_done, done, busy}, {28'b0, e});
        cur_busy = e[0];
        fd_cnt   += int'(frame_done);
        done_cnt += int'(done);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((expq.size() != 0 || cur_busy) && n < 1000) begin
            tick(tag);
            n++;
        end
        chk({tag, "_timeout"}, (n >= 1000) ? 32'd1 : 32'd0, 32'd0);
        tick({tag, "_idle"});
    endtask

    task automatic xfer(input string tag, input logic [PAT_W-1:0] p, input int r, input int g);
        pattern = p;
        rep     = CNT_W'(r);
        gap     = GAP_W'(g);
        start   = 1'b1;
        tick(tag);
        start   = 1'b0;
        drain(tag);
    endtask

    // called mid-cycle; outputs must clear without waiting for an edge
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        chk({tag, "_async"}, {28'b0, x, frame_done, done, busy}, 32'd0);
        expq.delete();
        cur_busy = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_hold"}, {28'b0, x, frame_done, done, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1;
        chk("reset_state", {28'b0, x, frame_done, done, busy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick("idle_after_reset");

        xfer("single_1011", 4'b1011, 0, 0);
        xfer("gap_1101", 4'b1101, 2, 2);
        xfer("b2b_1011", 4'b1011, 1, 0);

        // inputs disturbed during a transfer, then start held high
        pattern = 4'b1001; rep = '0; gap = '0; start = 1'b1;
        tick("ignore_start");
        for (int i = 2; i <= 5; i++) begin
            start   = i[0];
            pattern = 4'b0110;
            rep     = 4'd3;
            gap     = 3'd5;
            tick("ignore_start");
        end
        rep = '0; gap = '0; start = 1'b1;
        for (int i = 0; i < 14; i++) tick("held_start");
        start = 1'b0;
        drain("held_start");

        // reset in cycle 3 of a long transfer
        pattern = 4'b1111; rep = 4'd3; gap = '0; start = 1'b1;
        tick("pre_reset");
        start = 1'b0;
        tick("pre_reset");
        tick("pre_reset");
        do_reset("mid_reset");
        xfer("after_reset_0101", 4'b0101, 0, 0);

        // full-scale repeat
        fd_cnt = 0;
        done_cnt = 0;
        xfer("max_rep_1010", 4'b1010, 15, 0);
        chk("max_rep_frame_done_cnt", 32'(fd_cnt), 32'd16);
        chk("max_rep_done_cnt", 32'(done_cnt), 32'd1);

        // random traffic with occasional mid-transfer resets
        for (int c = 0; c < 3000; c++) begin
            start   = ($urandom_range(0, 3) != 0);
            pattern = PAT_W'($urandom);
            rep     = CNT_W'($urandom);
            gap     = GAP_W'($urandom);
            if ($urandom_range(0, 299) == 0) do_reset("rand_reset");
            else tick("rand");
        end
        start = 1'b0;
        drain("rand_end");

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/moore_seq_gen.md
# moore_seq_gen

Serial pattern generator: the transmit-side counterpart of the team's Moore sequence detector. On a start request it captures a PAT_W-bit pattern, a repeat count and an inter-frame gap length. It then drives the pattern MSB-first onto a one-bit serial line, one bit per clock, for the requested number of frames. It is used to stimulate detector blocks and as a standalone bit-stream source. The serial output is registered and is a function of state only (Moore style).

## Interface
- PAT_W, default 4: pattern length in bits (≥2).
- CNT_W, default 4: width of repeat input.
- GAP_W, default 3: width of gap input.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- pattern  in  PAT_W  bits to send, MSB first; captured on accepted start.
- repeat  in  CNT_W  frames to send = repeat+1; captured on accepted start.
- gap  in  GAP_W  zero bits inserted between consecutive frames; captured on accepted start.
- x  out  1  serial data.
- busy  out  1  high in SEND, GAP and DONE.
- frame_done  out  1  high during the last bit of every frame.
- done  out  1  one-cycle pulse after the last frame.

## Operation
- States: IDLE, SEND, GAP, DONE. Internal registers: pattern shift register (PAT_W), bit counter (ceil(log2 PAT_W)), frame counter (CNT_W), gap counter (GAP_W), and captured copies of pattern and gap.
- IDLE: x=0, busy=0. When start=1 at an edge, capture pattern, repeat and gap, and load the shift register. Next state is SEND.
- SEND: x = MSB of the shift register. Shift left each cycle. After PAT_W cycles:
  - If frames remain and captured gap>0, go to GAP.
  - If frames remain and gap=0, reload the pattern and go straight to SEND, with no idle bit.
  - Otherwise go to DONE.
- frame_done=1 during the cycle that presents bit 0 of each frame.
- GAP: x=0 for exactly gap cycles. Reload the pattern, then go to SEND.
- DONE: x=0, done=1, busy=1 for one cycle, then IDLE.
- The frame counter decrements at each frame end. Frame count repeat=2^CNT_W−1 gives 2^CNT_W frames, with no overflow or wrap.
- start is ignored outside IDLE. Input changes after capture have no effect on the transfer in progress.
- start held high continuously: a new transfer is accepted on the first IDLE cycle after DONE. This gives exactly one idle cycle (x=0) between transfers.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, x=0, busy=0, frame_done=0, done=0, all counters and the shift register 0.
- Latency: start accepted at edge k. Bit MSB appears on x in cycle k+1.
- Cycle counts, with F=repeat+1 and G=gap:
  - The last data bit is in cycle k + F·PAT_W + (F−1)·G.
  - done is high in the following cycle.
  - busy is high from k+1 through the done cycle inclusive.
- All outputs are registered. No combinational path from inputs to outputs.
- Reset asserted mid-frame or mid-gap: x drops to 0 immediately. No done or frame_done is produced. The block resumes in IDLE and accepts start on the first edge after rst deasserts.

## Test plan
- pattern=1011, repeat=0, gap=0, start at edge 0 → x=1,0,1,1 in cycles 1–4; frame_done only in cycle 4; done only in cycle 5; busy in cycles 1–5; x=0 from cycle 5.
- pattern=1101, repeat=2, gap=2 → x=1101 00 1101 00 1101 over cycles 1–16; frame_done in cycles 4, 10 and 16; done in cycle 17.
- pattern=1011, repeat=1, gap=0 → x=10111011 in cycles 1–8 with no idle bit; frame_done in cycles 4 and 8; done in cycle 9.
- Transfer with pattern=1001. Toggle start and change pattern to 0110 during cycles 2–5 → output remains 1001, and no second transfer starts. Then start held high continuously → next transfer begins with one idle cycle after done.
- Reset pulse in cycle 3 of a pattern=1111, repeat=3 transfer → x, busy, frame_done and done go to 0 asynchronously. A later start with pattern=0101, repeat=0 produces a clean 0101 frame.
- repeat=4'hF, gap=0, pattern=1010 → 64 contiguous alternating bits; exactly 16 frame_done pulses; one done.
